// File: rtl/parallel_load_fifo.sv
// parallel_load_fifo: parallel-in, serial-out word FIFO.
// A WIDTH*DEPTH-bit load is replayed as DEPTH words of WIDTH bits, one per
// accepted output beat. By default the most significant word leaves first.
// Optional macro PARALLEL_LOAD_LSW_FIRST_EN: emit the least significant word first.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high; valid never depends on ready and, once raised, is held
// with stable data until that transfer. load_ready alone looks at out_ready
// combinationally so a new load can be captured on the edge that drains the
// final word, giving back-to-back bursts without a bubble.
module parallel_load_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [WIDTH*DEPTH-1:0] load_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       outp,
    output logic                   out_last
);
    localparam int TW = WIDTH * DEPTH;
    localparam int CW = ($clog2(DEPTH + 1) > 1) ? $clog2(DEPTH + 1) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic {
        EMPTY = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] count, count_n;
    logic [TW-1:0] shreg, shreg_n;
    logic [TW-1:0] load_words;
    logic          load_fire;
    logic          out_fire;

`ifdef PARALLEL_LOAD_LSW_FIRST_EN
    // Reverse the word order so the least significant word sits at the head.
    always_comb begin
        load_words = '0;
        for (int i = 0; i < DEPTH; i++) begin
            load_words[WIDTH*(DEPTH-1-i) +: WIDTH] = load_data[WIDTH*i +: WIDTH];
        end
    end
`else
    assign load_words = load_data;
`endif

    assign out_valid  = (state == SHIFT);
    assign out_last   = out_valid && (count == ONE);
    assign outp       = shreg[TW-1 -: WIDTH];
    assign out_fire   = out_valid && out_ready;
    assign load_ready = (state == EMPTY) || (out_fire && (count == ONE));
    assign load_fire  = load_valid && load_ready;

    // Next-state logic: a load (re)fills the register; otherwise a beat shifts it.
    always_comb begin
        state_n = state;
        count_n = count;
        shreg_n = shreg;
        if (load_fire) begin
            state_n = SHIFT;
            count_n = FULL;
            shreg_n = load_words;
        end else if (out_fire) begin
            shreg_n = shreg << WIDTH;
            count_n = count - ONE;
            if (count == ONE) begin
                state_n = EMPTY;
            end
        end
    end

    // State, count and word register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
            count <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            shreg <= shreg_n;
        end
    end
endmodule

// File: tb/tb_parallel_load_fifo.sv
// Bench for parallel_load_fifo: WIDTH=8/DEPTH=4 instance plus a WIDTH=4/DEPTH=1
// instance. A queue model of the words still owed tracks expected outputs.
module tb_parallel_load_fifo;
    localparam int W = 8;
    localparam int D = 4;

    // Clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic           load_valid, load_ready, out_valid, out_ready, out_last;
    logic [W*D-1:0] load_data;
    logic [W-1:0]   outp;

    logic       d1_load_valid, d1_load_ready, d1_out_valid, d1_out_ready, d1_out_last;
    logic [3:0] d1_load_data, d1_outp;

    parallel_load_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .out_valid(out_valid), .out_ready(out_ready), .outp(outp), .out_last(out_last)
    );

    parallel_load_fifo #(.WIDTH(4), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .load_valid(d1_load_valid), .load_ready(d1_load_ready), .load_data(d1_load_data),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready), .outp(d1_outp), .out_last(d1_out_last)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Model: words still owed for the current load, head first.
    logic [W-1:0] exp_q[$];
    logic [3:0]   exp1_q[$];

    // Observed output beats.
    logic [W-1:0] got_q[$];
    int           got_cyc[$];
    logic         got_last[$];
    logic [3:0]   got1_q[$];
    int           got1_cyc[$];
    logic         got1_last[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", name, got, exp);
        else n_pass++;
    endtask

    function automatic logic m_ready();
        return (exp_q.size() == 0) || (out_ready && exp_q.size() == 1);
    endfunction

    function automatic logic m1_ready();
        return (exp1_q.size() == 0) || (d1_out_ready && exp1_q.size() == 1);
    endfunction

    // Model update: a load replaces whatever remains (at most the final word
    // being consumed now); otherwise an accepted beat removes the head.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            exp1_q.delete();
        end else begin
            if (load_valid && m_ready()) begin
                exp_q.delete();
                for (int i = 0; i < D; i++) begin
`ifdef PARALLEL_LOAD_LSW_FIRST_EN
                    exp_q.push_back(load_data[W*i +: W]);
`else
                    exp_q.push_back(load_data[W*(D-1-i) +: W]);
`endif
                end
            end else if (exp_q.size() > 0 && out_ready) begin
                void'(exp_q.pop_front());
            end
            if (d1_load_valid && m1_ready()) begin
                exp1_q.delete();
                exp1_q.push_back(d1_load_data);
            end else if (exp1_q.size() > 0 && d1_out_ready) begin
                void'(exp1_q.pop_front());
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
        check("out_last", {31'b0, out_last}, {31'b0, exp_q.size() == 1});
        check("load_ready", {31'b0, load_ready}, {31'b0, m_ready()});
        if (exp_q.size() > 0) check("outp", {24'b0, outp}, {24'b0, exp_q[0]});
        if (!rst) check("outp_in_reset", {24'b0, outp}, 32'h0);
        check("d1_out_valid", {31'b0, d1_out_valid}, {31'b0, exp1_q.size() > 0});
        check("d1_out_last", {31'b0, d1_out_last}, {31'b0, exp1_q.size() == 1});
        check("d1_load_ready", {31'b0, d1_load_ready}, {31'b0, m1_ready()});
        if (exp1_q.size() > 0) check("d1_outp", {28'b0, d1_outp}, {28'b0, exp1_q[0]});
        if (out_valid && out_ready) begin
            got_q.push_back(outp);
            got_cyc.push_back(cyc);
            got_last.push_back(out_last);
        end
        if (d1_out_valid && d1_out_ready) begin
            got1_q.push_back(d1_outp);
            got1_cyc.push_back(cyc);
            got1_last.push_back(d1_out_last);
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_got();
        got_q.delete();
        got_cyc.delete();
        got_last.delete();
    endtask

    task automatic send_load(input logic [W*D-1:0] d);
        bit done = 1'b0;
        load_data  = d;
        load_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = load_ready;
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        if (!done) begin
            n_total++;
            $display("FAIL load_timeout got=no_accept exp=accept data=%h", d);
        end
    endtask

    // Literal pin of the observed beat sequence.
    task automatic check_seq(input string name, input logic [W-1:0] exp[$],
                             input bit chk_timing);
        check({name, "_len"}, got_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_w%0d", name, i), {24'b0, got_q[i]}, {24'b0, exp[i]});
            if (chk_timing) begin
                check($sformatf("%s_last%0d", name, i), {31'b0, got_last[i]}, {31'b0, (i % D) == D - 1});
                check($sformatf("%s_cyc%0d", name, i), got_cyc[i], got_cyc[0] + i);
            end
        end
    endtask

    logic [W-1:0] e[$];
    int pat[7] = '{1, 0, 0, 1, 0, 1, 1};

    initial begin
        // Reset then idle
        rst = 1'b0;
        load_valid = 1'b0; load_data = '0; out_ready = 1'b0;
        d1_load_valid = 1'b0; d1_load_data = '0; d1_out_ready = 1'b0;
        step();
        step();
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_out_last", {31'b0, out_last}, 32'h0);
        check("rst_outp", {24'b0, outp}, 32'h0);
        check("rst_load_ready", {31'b0, load_ready}, 32'h1);
        check("rst_d1_load_ready", {31'b0, d1_load_ready}, 32'h1);
        rst = 1'b1;
        out_ready = 1'b1;
        step();

        // DEPTH=1: back-to-back single-word loads
        d1_out_ready = 1'b1;
        d1_load_data = 4'h5; d1_load_valid = 1'b1;
        step();
        d1_load_data = 4'hA;
        step();
        d1_load_valid = 1'b0;
        step();
        step();
        check("d1_len", got1_q.size(), 2);
        if (got1_q.size() == 2) begin
            check("d1_w0", {28'b0, got1_q[0]}, 32'h5);
            check("d1_w1", {28'b0, got1_q[1]}, 32'hA);
            check("d1_last0", {31'b0, got1_last[0]}, 32'h1);
            check("d1_last1", {31'b0, got1_last[1]}, 32'h1);
            check("d1_consecutive", got1_cyc[1], got1_cyc[0] + 1);
        end

        // Basic unload
        clear_got();
        send_load(32'hA1B2C3D4);
        repeat (5) step();
`ifdef PARALLEL_LOAD_LSW_FIRST_EN
        e = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
`else
        e = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
`endif
        check_seq("basic", e, 1'b1);

        // Backpressure, with a pending load that must wait for the last beat
        clear_got();
        out_ready  = 1'b0;
        load_data  = 32'h11223344;
        load_valid = 1'b1;
        step();
        load_data = 32'h99AABBCC;
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i][0];
            step();
        end
        load_valid = 1'b0;
        out_ready  = 1'b1;
        repeat (5) step();
`ifdef PARALLEL_LOAD_LSW_FIRST_EN
        e = {8'h44, 8'h33, 8'h22, 8'h11, 8'hCC, 8'hBB, 8'hAA, 8'h99};
`else
        e = {8'h11, 8'h22, 8'h33, 8'h44, 8'h99, 8'hAA, 8'hBB, 8'hCC};
`endif
        check_seq("bp", e, 1'b0);
        if (got_cyc.size() == 8) begin
            check("bp_gap1", got_cyc[1] - got_cyc[0], 3);
            check("bp_gap2", got_cyc[2] - got_cyc[0], 5);
            check("bp_gap3", got_cyc[3] - got_cyc[0], 6);
            check("bp_no_bubble", got_cyc[4] - got_cyc[3], 1);
            check("bp_last3", {31'b0, got_last[3]}, 32'h1);
            check("bp_last2", {31'b0, got_last[2]}, 32'h0);
        end

        // Back-to-back loads: 8 words in 8 consecutive cycles
        clear_got();
        send_load(32'h01020304);
        send_load(32'h05060708);
        repeat (5) step();
`ifdef PARALLEL_LOAD_LSW_FIRST_EN
        e = {8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05};
`else
        e = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
`endif
        check_seq("b2b", e, 1'b1);

        // Reset mid-burst, asserted between edges
        clear_got();
        send_load(32'hDEADBEEF);
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        check("async_out_valid", {31'b0, out_valid}, 32'h0);
        check("async_out_last", {31'b0, out_last}, 32'h0);
        check("async_outp", {24'b0, outp}, 32'h0);
        check("async_load_ready", {31'b0, load_ready}, 32'h1);
        step();
        rst = 1'b1;
        step();
        send_load(32'h0BADF00D);
        repeat (5) step();
`ifdef PARALLEL_LOAD_LSW_FIRST_EN
        e = {8'hEF, 8'hBE, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
`else
        e = {8'hDE, 8'hAD, 8'h0B, 8'hAD, 8'hF0, 8'h0D};
`endif
        check_seq("midrst", e, 1'b0);

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
